// File: rtl/recirculador_pkg.sv
// Package: recirculador_pkg
// Shared state encoding, default geometry and the statistics counter width
// for the parametrised lane recirculator.
package recirculador_pkg;

   typedef enum logic [1:0] {
      ST_FWD   = 2'd0,
      ST_REC   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_LANES = 4;
   localparam int DEF_DEPTH = 4;
   localparam int STATS_W   = 16;

   // Saturating increment for the per-lane push statistics.
   function automatic logic [STATS_W-1:0] satInc(input logic [STATS_W-1:0] v);
      return (v == '1) ? v : v + STATS_W'(1);
   endfunction

endpackage

// File: rtl/recirc_lane_fifo.sv
// Module: recirc_lane_fifo
// One recirculation FIFO for a single lane. Show-ahead head output, push is
// refused when full (even with a simultaneous pop), pop is refused when empty.
// Also reports whether the FIFO will be empty after this cycle's pop, which the
// top-level drain logic needs.
module recirc_lane_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_emptyNext
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_empty     = (r_count == '0);
   assign o_full      = (r_count == COUNT_MAX);
   assign o_head      = r_mem[r_rdPtr];
   assign w_doPush    = i_push && !o_full;
   assign w_doPop     = i_pop && !o_empty;
   assign o_emptyNext = o_empty || ((r_count == COUNT_ONE) && i_pop);

   // Storage array; stale contents are harmless because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (w_doPush && !reset) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally at DEPTH; the count tracks occupancy 0..DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + COUNT_ONE;
            2'b01:   r_count <= r_count - COUNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/recirculador_param.sv
// Module: recirculador_param
// Routes LANES lanes of WIDTH-bit words either to a registered forward path
// or into per-lane recirculation FIFOs, under a three-state mode FSM that
// drains the FIFOs before returning to forwarding.
// Optional build macro: RECIRC_STATS_EN adds the recCount port with one
// saturating 16-bit push counter per lane.
module recirculador_param
   import recirculador_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   selector_IDLE,
   input  logic [LANES*WIDTH-1:0] dataIn,
   input  logic [LANES-1:0]       validIn,
   output logic [LANES-1:0]       readyIn,
   output logic [LANES*WIDTH-1:0] dataFwd,
   output logic [LANES-1:0]       validFwd,
   output logic [LANES*WIDTH-1:0] dataRec,
   output logic [LANES-1:0]       validRec,
   input  logic [LANES-1:0]       popRec,
   output logic [LANES-1:0]       fifoFull,
   output logic [1:0]             state
`ifdef RECIRC_STATS_EN
   ,
   output logic [LANES*STATS_W-1:0] recCount
`endif
);

   state_t                 r_state;
   logic [LANES*WIDTH-1:0] r_dataFwd;
   logic [LANES-1:0]       r_validFwd;
   logic [LANES-1:0]       w_ready;
   logic [LANES-1:0]       w_push;
   logic [LANES-1:0]       w_empty;
   logic [LANES-1:0]       w_full;
   logic [LANES-1:0]       w_emptyNext;
   logic                   w_allEmptyNext;

   assign state          = r_state;
   assign dataFwd        = r_dataFwd;
   assign validFwd       = r_validFwd;
   assign readyIn        = w_ready;
   assign validRec       = ~w_empty;
   assign fifoFull       = w_full;
   assign w_push         = validIn & w_ready & {LANES{r_state == ST_REC}};
   assign w_allEmptyNext = &w_emptyNext;

   // Accept everything while forwarding, only into non-full FIFOs while recirculating, nothing while draining.
   always_comb begin
      w_ready = '0;
      case (r_state)
         ST_FWD:  w_ready = '1;
         ST_REC:  w_ready = ~w_full;
         default: w_ready = '0;
      endcase
   end

   // Mode FSM: an empty drain wins over a returning idle request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FWD;
      end else begin
         case (r_state)
            ST_FWD: begin
               if (selector_IDLE) begin
                  r_state <= ST_REC;
               end
            end
            ST_REC: begin
               if (!selector_IDLE) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_allEmptyNext) begin
                  r_state <= ST_FWD;
               end else if (selector_IDLE) begin
                  r_state <= ST_REC;
               end
            end
            default: r_state <= ST_FWD;
         endcase
      end
   end

   // Forward path register; data lanes hold their last value when not refreshed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dataFwd  <= '0;
         r_validFwd <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            r_validFwd[i] <= (r_state == ST_FWD) && validIn[i];
            if ((r_state == ST_FWD) && validIn[i]) begin
               r_dataFwd[i*WIDTH +: WIDTH] <= dataIn[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : gLane
      recirc_lane_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) uFifo (
         .clk         (clk),
         .reset       (reset),
         .i_push      (w_push[g]),
         .i_data      (dataIn[g*WIDTH +: WIDTH]),
         .i_pop       (popRec[g]),
         .o_head      (dataRec[g*WIDTH +: WIDTH]),
         .o_empty     (w_empty[g]),
         .o_full      (w_full[g]),
         .o_emptyNext (w_emptyNext[g])
      );
   end

`ifdef RECIRC_STATS_EN
   logic [STATS_W-1:0] r_recCount [LANES];

   // Per-lane count of words actually pushed, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LANES; i++) begin
            r_recCount[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (w_push[i]) begin
               r_recCount[i] <= satInc(r_recCount[i]);
            end
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : gStats
      assign recCount[g*STATS_W +: STATS_W] = r_recCount[g];
   end
`endif

endmodule

// File: tb/tb_recirculador_param.sv
// Testbench: tb_recirculador_param
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based behavioural model of the recirculator.
module tb_recirculador_param;
   import recirculador_pkg::*;

   localparam int W = 8;
   localparam int L = 4;
   localparam int D = 4;

   logic           clk;
   logic           reset;
   logic           selector_IDLE;
   logic [L*W-1:0] dataIn;
   logic [L-1:0]   validIn;
   logic [L-1:0]   readyIn;
   logic [L*W-1:0] dataFwd;
   logic [L-1:0]   validFwd;
   logic [L*W-1:0] dataRec;
   logic [L-1:0]   validRec;
   logic [L-1:0]   popRec;
   logic [L-1:0]   fifoFull;
   logic [1:0]     state;
`ifdef RECIRC_STATS_EN
   logic [L*STATS_W-1:0] recCount;
   int                   mRecCount [L];
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   // Model: one queue per lane plus the mode and the forward register contents.
   logic [W-1:0]   mQ [L][$];
   state_t         mState;
   logic [L*W-1:0] mFwdData;
   logic [L-1:0]   mFwdValid;

   recirculador_param #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
      .clk           (clk),
      .reset         (reset),
      .selector_IDLE (selector_IDLE),
      .dataIn        (dataIn),
      .validIn       (validIn),
      .readyIn       (readyIn),
      .dataFwd       (dataFwd),
      .validFwd      (validFwd),
      .dataRec       (dataRec),
      .validRec      (validRec),
      .popRec        (popRec),
      .fifoFull      (fifoFull),
      .state         (state)
`ifdef RECIRC_STATS_EN
      ,
      .recCount      (recCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < L; i++) begin
         mQ[i].delete();
`ifdef RECIRC_STATS_EN
         mRecCount[i] = 0;
`endif
      end
      mState    = ST_FWD;
      mFwdData  = '0;
      mFwdValid = '0;
   endtask

   // Drive one cycle of inputs at the falling edge, compare every output
   // with the model, then advance the model across the coming rising edge.
   task automatic applyStimulus(input logic rst, input logic sel, input logic [L-1:0] vin,
                                input logic [L*W-1:0] din, input logic [L-1:0] pop);
      logic [L-1:0] expReady;
      logic [L-1:0] expValidRec;
      logic [L-1:0] expFull;
      bit           allEmpty;
      @(negedge clk);
      reset         = rst;
      selector_IDLE = sel;
      validIn       = vin;
      dataIn        = din;
      popRec        = pop;
      #1;
      for (int i = 0; i < L; i++) begin
         expValidRec[i] = (mQ[i].size() != 0);
         expFull[i]     = (mQ[i].size() == D);
         if (mState == ST_FWD)      expReady[i] = 1'b1;
         else if (mState == ST_REC) expReady[i] = (mQ[i].size() < D);
         else                       expReady[i] = 1'b0;
      end
      checkOutput("readyIn",  64'(readyIn),  64'(expReady));
      checkOutput("validFwd", 64'(validFwd), 64'(mFwdValid));
      checkOutput("dataFwd",  64'(dataFwd),  64'(mFwdData));
      checkOutput("validRec", 64'(validRec), 64'(expValidRec));
      checkOutput("fifoFull", 64'(fifoFull), 64'(expFull));
      checkOutput("state",    64'(state),    64'(mState));
      for (int i = 0; i < L; i++) begin
         if (mQ[i].size() != 0) begin
            checkOutput("dataRec", 64'(dataRec[i*W +: W]), 64'(mQ[i][0]));
         end
`ifdef RECIRC_STATS_EN
         checkOutput("recCount", 64'(recCount[i*STATS_W +: STATS_W]), 64'(mRecCount[i]));
`endif
      end
      if (rst) begin
         modelReset();
      end else begin
         if (mState == ST_FWD) begin
            mFwdValid = vin;
            for (int i = 0; i < L; i++) begin
               if (vin[i]) mFwdData[i*W +: W] = din[i*W +: W];
            end
         end else begin
            mFwdValid = '0;
         end
         for (int i = 0; i < L; i++) begin
            if (pop[i] && mQ[i].size() != 0) void'(mQ[i].pop_front());
         end
         if (mState == ST_REC) begin
            for (int i = 0; i < L; i++) begin
               if (vin[i] && expReady[i]) begin
                  mQ[i].push_back(din[i*W +: W]);
`ifdef RECIRC_STATS_EN
                  if (mRecCount[i] < 65535) mRecCount[i]++;
`endif
               end
            end
         end
         allEmpty = 1'b1;
         for (int i = 0; i < L; i++) begin
            if (mQ[i].size() != 0) allEmpty = 1'b0;
         end
         case (mState)
            ST_FWD:   if (sel) mState = ST_REC;
            ST_REC:   if (!sel) mState = ST_DRAIN;
            ST_DRAIN: begin
               if (allEmpty) mState = ST_FWD;
               else if (sel) mState = ST_REC;
            end
            default:  mState = ST_FWD;
         endcase
      end
   endtask

   initial begin
      logic           sel;
      logic [L-1:0]   vin;
      logic [L*W-1:0] din;
      logic [L-1:0]   pop;
      reset         = 1'b1;
      selector_IDLE = 1'b0;
      validIn       = '0;
      dataIn        = '0;
      popRec        = '0;
      modelReset();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);

      // Forward path
      applyStimulus(1'b0, 1'b0, 4'hF, 32'hFFEEDDCC, 4'h0);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      checkOutput("t1_validFwd", 64'(validFwd), 64'h0F);
      checkOutput("t1_dataFwd",  64'(dataFwd),  64'hFFEEDDCC);
      checkOutput("t1_validRec", 64'(validRec), 64'h00);

      // Enter recirculation and push one word per lane
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 4'h0);
      applyStimulus(1'b0, 1'b1, 4'hF, 32'hBBAA9988, 4'h0);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 4'h0);
      checkOutput("t2_validRec", 64'(validRec), 64'h0F);
      checkOutput("t2_dataRec",  64'(dataRec),  64'hBBAA9988);
      checkOutput("t2_validFwd", 64'(validFwd), 64'h00);
      checkOutput("t2_state",    64'(state),    64'(ST_REC));

      // Fill lane 0, hold a word against a full FIFO, then release one slot
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 4'hF);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 4'h1, 32'(k), 4'h0);
      end
      applyStimulus(1'b0, 1'b1, 4'h1, 32'h05, 4'h0);
      checkOutput("t3_full0",  64'(fifoFull[0]), 64'h1);
      checkOutput("t3_ready0", 64'(readyIn[0]),  64'h0);
      applyStimulus(1'b0, 1'b1, 4'h1, 32'h05, 4'h1);
      applyStimulus(1'b0, 1'b1, 4'h1, 32'h05, 4'h0);
      checkOutput("t3_head0",  64'(dataRec[7:0]), 64'h02);
      checkOutput("t3_ready0b", 64'(readyIn[0]), 64'h1);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 4'h0);
      checkOutput("t3_full0b", 64'(fifoFull[0]), 64'h1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 4'h1);
      end

      // Lane 2 holds two words, idle drops, drain them out
      applyStimulus(1'b0, 1'b1, 4'h4, 32'h00770000, 4'h0);
      applyStimulus(1'b0, 1'b1, 4'h4, 32'h00880000, 4'h0);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h12345678, 4'h0);
      checkOutput("t4_state",  64'(state),   64'(ST_DRAIN));
      checkOutput("t4_ready",  64'(readyIn), 64'h0);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h4);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h4);
      checkOutput("t4_head2", 64'(dataRec[23:16]), 64'h88);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      checkOutput("t4_stateFwd", 64'(state), 64'(ST_FWD));

      // Reset in the middle of recirculation with every FIFO full
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 4'h0);
      for (int k = 0; k < D; k++) begin
         applyStimulus(1'b0, 1'b1, 4'hF, $urandom, 4'h0);
      end
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0, 4'h0);
      checkOutput("t5_fullBefore", 64'(fifoFull), 64'h0F);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      checkOutput("t5_full",     64'(fifoFull), 64'h0);
      checkOutput("t5_validRec", 64'(validRec), 64'h0);
      checkOutput("t5_validFwd", 64'(validFwd), 64'h0);
      checkOutput("t5_state",    64'(state),    64'(ST_FWD));

      // Randomized traffic with occasional mode flips and resets
      sel = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) sel = ~sel;
         vin = L'($urandom);
         pop = L'($urandom);
         for (int i = 0; i < L; i++) begin
            din[i*W +: W] = W'($urandom);
         end
         applyStimulus(($urandom_range(0, 199) == 0), sel, vin, din, pop);
      end

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
